// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART echo design. Holds the frame
//               data width, the default baud divider and the state type used
//               by both the receive and transmit state machines.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Payload bits per 8N1 frame
  localparam int DATA_BITS = 8;

  // 200 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 1736;

  // Common phase encoding for the RX and TX serial engines
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. rdata always shows
//               the head entry; pop advances past it. A push while full is
//               ignored and a pop while empty is ignored.
// Ports       : clock  - rising-edge clock
//               reset  - synchronous active-high reset (empties the FIFO)
//               push   - write wdata at the tail
//               pop    - discard the head entry
//               wdata  - write data
//               rdata  - head entry (valid while !empty)
//               full   - no free entries
//               empty  - no stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0] c_ptr_one = (c_aw + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  // Pointers carry one extra wrap bit: equal addresses with differing wrap
  // bits means the writer is a full lap ahead.
  assign full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign w_wr_en = push && !full;
  assign w_rd_en = pop && !empty;
  assign rdata   = r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_top.sv
`default_nettype none
// ============================================================================
// Module      : uart_top
// Description : UART echo. Receives 8N1 frames on sig_rx, buffers each valid
//               byte in a FIFO and retransmits the bytes in order on sig_tx.
// Ports       : clock  - system clock, rising-edge active
//               reset  - synchronous active-high reset
//               sig_rx - asynchronous serial input, idles high
//               sig_tx - registered serial output, idles high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_rx,
  output logic sig_tx
);

  localparam int             c_cw        = $clog2(CLKS_PER_BIT);
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
  localparam logic [c_cw-1:0] c_bit_last = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [c_cw-1:0] c_half_last = c_cw'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     c_last_bit  = 3'(DATA_BITS - 1);

  // --------------------------------------------------------------------------
  // Input synchronizer plus one delayed copy for falling-edge detection
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= sig_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO between receiver and transmitter
  // --------------------------------------------------------------------------
  logic                 r_push;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_fifo_rdata;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] r_rx_shift;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_push),
    .pop   (w_pop),
    .wdata (r_rx_shift),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  uart_state_t          r_rx_state;
  uart_state_t          w_rx_state_nxt;
  logic [c_cw-1:0]      r_rx_baud;
  logic [c_cw-1:0]      w_rx_baud_nxt;
  logic [2:0]           r_rx_bit;
  logic [2:0]           w_rx_bit_nxt;
  logic [DATA_BITS-1:0] w_rx_shift_nxt;
  logic                 w_push_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_state <= IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_push     <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_baud  <= w_rx_baud_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_push     <= w_push_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_baud_nxt  = r_rx_baud + c_cnt_one;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_push_nxt     = 1'b0;
    case (r_rx_state)
      IDLE: begin
        w_rx_baud_nxt = '0;
        if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = START;
      end
      START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (r_rx_baud == c_half_last) begin
          w_rx_baud_nxt  = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_rx_baud == c_bit_last) begin
          w_rx_baud_nxt  = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == c_last_bit) w_rx_state_nxt = STOP;
          else                        w_rx_bit_nxt   = r_rx_bit + 3'd1;
        end
      end
      STOP: begin
        // A low stop bit is a framing error: the byte is simply not pushed.
        if (r_rx_baud == c_bit_last) begin
          w_rx_baud_nxt  = '0;
          w_push_nxt     = r_rx_sync;
          w_rx_state_nxt = IDLE;
        end
      end
      default: w_rx_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  uart_state_t          r_tx_state;
  uart_state_t          w_tx_state_nxt;
  logic [c_cw-1:0]      r_tx_baud;
  logic [c_cw-1:0]      w_tx_baud_nxt;
  logic [2:0]           r_tx_bit;
  logic [2:0]           w_tx_bit_nxt;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [DATA_BITS-1:0] w_tx_shift_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;

  assign sig_tx = r_tx;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_baud  <= w_tx_baud_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_baud_nxt  = r_tx_baud + c_cnt_one;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_pop          = 1'b0;
    case (r_tx_state)
      IDLE: begin
        w_tx_baud_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_tx_shift_nxt = w_fifo_rdata;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = START;
        end
      end
      START: begin
        if (r_tx_baud == c_bit_last) begin
          w_tx_baud_nxt  = '0;
          w_tx_state_nxt = DATA;
        end
      end
      DATA: begin
        if (r_tx_baud == c_bit_last) begin
          w_tx_baud_nxt = '0;
          if (r_tx_bit == c_last_bit) begin
            w_tx_state_nxt = STOP;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_BITS-1:1]};
          end
        end
      end
      STOP: begin
        if (r_tx_baud == c_bit_last) begin
          w_tx_baud_nxt  = '0;
          w_tx_state_nxt = IDLE;
        end
      end
      default: w_tx_state_nxt = IDLE;
    endcase

    // Output is derived from the upcoming state so the registered line
    // changes on the same edge as the state register.
    case (w_tx_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_tx_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_top
// Description : Self-checking bench for uart_top. Drives serial frames into
//               sig_rx, keeps a queue of bytes that should be echoed, and
//               decodes every frame seen on sig_tx against that queue,
//               including per-sample bit timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_top;

  localparam int CPB      = 16;
  localparam int DEPTH    = 16;
  localparam int MAX_WAIT = 20000;

  logic clock;
  logic reset;
  logic sig_rx;
  logic sig_tx;

  int   checks;
  int   errors;

  logic [7:0] exp_q [$];
  int         frames_seen;
  bit         in_frame;
  time        tx_fall_time;
  time        rx_fall_time;
  logic       mon_prev;

  uart_top #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .sig_rx (sig_rx),
    .sig_tx (sig_tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Line monitor: any falling edge on sig_tx is a frame start. Each of the
  // 10 bits must hold its value for exactly CPB samples.
  // --------------------------------------------------------------------------
  initial begin
    mon_prev     = 1'b1;
    frames_seen  = 0;
    in_frame     = 1'b0;
    tx_fall_time = 0;
    forever begin
      @(negedge clock);
      if (!reset && mon_prev && !sig_tx) begin : frame
        logic [7:0] expb;
        logic [9:0] bits;
        logic [9:0] got;
        int         bad;
        bit         aborted;
        frames_seen++;
        tx_fall_time = $time;
        in_frame     = 1'b1;
        check("tx_frame_expected", int'(exp_q.size() > 0), 1);
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        bits    = {1'b1, expb, 1'b0};
        got     = '0;
        bad     = 0;
        aborted = 1'b0;
        for (int s = 0; s < 10 * CPB; s++) begin
          if (s > 0) @(negedge clock);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (sig_tx !== bits[s / CPB]) bad++;
          if (s % CPB == CPB / 2) got[s / CPB] = sig_tx;
        end
        in_frame = 1'b0;
        if (!aborted) begin
          check("tx_byte", int'(got[8:1]), int'(expb));
          check("tx_start_stop", int'({got[9], got[0]}), 2);
          check("tx_bit_timing", bad, 0);
        end
      end
      mon_prev = reset ? 1'b1 : sig_tx;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap_bits);
    @(negedge clock);
    sig_rx       = 1'b0;
    rx_fall_time = $time;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      sig_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    sig_rx = stop_bit;
    if (stop_bit) exp_q.push_back(b);
    repeat (CPB) @(negedge clock);
    sig_rx = 1'b1;
    repeat (gap_bits * CPB) @(negedge clock);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < MAX_WAIT) begin
      @(negedge clock);
      n++;
    end
    check(tag, exp_q.size() + int'(in_frame), 0);
  endtask

  task automatic quiet(input string tag, input int nbits);
    int start_frames;
    int lows;
    start_frames = frames_seen;
    lows = 0;
    repeat (nbits * CPB) begin
      @(negedge clock);
      if (sig_tx !== 1'b1) lows++;
    end
    check({tag, "_frames"}, frames_seen - start_frames, 0);
    check({tag, "_tx_low"}, lows, 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin : main
    logic [7:0] msg [11];
    int         base;
    int         lat;
    int         n;
    logic [7:0] rb;
    int         gap;

    msg = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h09,
            8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    sig_rx = 1'b1;

    // Reset with idle line
    repeat (5) @(negedge clock);
    check("reset_tx_during", int'(sig_tx), 1);
    reset = 1'b0;
    @(negedge clock);
    check("reset_tx_after", int'(sig_tx), 1);
    quiet("reset_quiet", 20);

    // Single frame and end-to-end latency
    send_frame(8'h68, 1'b1, 2);
    wait_drain("drain_single");
    check("single_frames", frames_seen, 1);
    lat = int'((tx_fall_time - rx_fall_time) / 10);
    check("latency_in_range", int'(lat >= (19 * CPB) / 2 && lat <= (19 * CPB) / 2 + 6), 1);

    // Text stream, twice
    base = frames_seen;
    repeat (2) begin
      for (int i = 0; i < 11; i++) send_frame(msg[i], 1'b1, 5);
    end
    wait_drain("drain_stream");
    check("stream_frames", frames_seen - base, 22);

    // Short low glitch must not start a frame
    @(negedge clock);
    sig_rx = 1'b0;
    repeat (5) @(negedge clock);
    sig_rx = 1'b1;
    quiet("glitch_quiet", 20);

    // Framing error then a good frame
    base = frames_seen;
    send_frame(8'h55, 1'b0, 2);
    quiet("framing_quiet", 12);
    send_frame(8'h41, 1'b1, 2);
    wait_drain("drain_framing");
    check("framing_frames", frames_seen - base, 1);

    // Random bytes with random gaps, including back-to-back
    base = frames_seen;
    repeat (16) begin
      rb  = 8'($urandom_range(0, 255));
      gap = int'($urandom_range(0, 3));
      send_frame(rb, 1'b1, gap);
    end
    wait_drain("drain_random");
    check("random_frames", frames_seen - base, 16);

    // Reset in the middle of transmitting 0x6F, during a zero data bit
    send_frame(8'h6F, 1'b1, 0);
    n = 0;
    while (!in_frame && n < MAX_WAIT) begin
      @(negedge clock);
      n++;
    end
    check("reset_tx_started", int'(in_frame), 1);
    repeat (5 * CPB + CPB / 2) @(negedge clock);
    check("pre_reset_tx_low", int'(sig_tx), 0);
    reset = 1'b1;
    @(negedge clock);
    check("reset_tx_next_cycle", int'(sig_tx), 1);
    exp_q.delete();
    reset = 1'b0;
    quiet("post_reset_quiet", 20);
    base = frames_seen;
    send_frame(8'h42, 1'b1, 2);
    wait_drain("drain_post_reset");
    check("post_reset_frames", frames_seen - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
